// File: rtl/rps_match_driver.sv
// rps_match_driver: initiator side of the stone/paper/scissors round interface.
// Presents the user's move (P1) and an LFSR-chosen move (P2) to the game core,
// pulses game_start, samples game_winner RESULT_LATENCY cycles later and keeps
// the match score until one player reaches ROUNDS_TO_WIN.
// Optional build macro: RPS_AUTOPLAY_EN (rounds restart automatically after
// the first user_go edge).
//
// Handshake: game_start is a one-cycle strobe with no ready/ack; the game core
// must present game_winner during the cycle that ends RESULT_LATENCY cycles
// after the game_start cycle, where it is captured on that closing clock edge.
module rps_match_driver #(
  parameter int unsigned ROUNDS_TO_WIN  = 3,
  parameter int unsigned RESULT_LATENCY = 2,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [1:0] user_move,
  input  logic       user_go,
  output logic [1:0] game_p1,
  output logic [1:0] game_p2,
  output logic       game_start,
  input  logic [1:0] game_winner,
  output logic [2:0] p1_score,
  output logic [2:0] p2_score,
  output logic       match_over,
  output logic [1:0] match_winner,
  output logic       busy,
  output logic       last_invalid
);

  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [7:0] SEED     = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [3:0] CNT_LOAD = 4'(RESULT_LATENCY - 1);
  localparam logic [2:0] WIN      = 3'(ROUNDS_TO_WIN);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic        go_q;
  logic        go_edge;
  logic        start_round;
  logic [7:0]  lfsr;
  logic        lfsr_fb;
  logic [1:0]  p2_pick;
  logic [3:0]  cnt;

  assign go_edge = user_go & ~go_q;
  // Taps 8,6,5,4 counted from 1 at the LSB.
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

`ifdef RPS_AUTOPLAY_EN
  logic armed;

  // Autoplay arms on the first user edge seen in IDLE and stays armed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else if (ena && state == S_IDLE && go_edge) begin
      armed <= 1'b1;
    end
  end

  assign start_round = go_edge | armed;
`else
  assign start_round = go_edge;
`endif

  // P2 move: first legal 2-bit field of the LFSR, falling back to paper.
  always_comb begin
    p2_pick = 2'b01;
    if (lfsr[1:0] != 2'b11) begin
      p2_pick = lfsr[1:0];
    end else if (lfsr[3:2] != 2'b11) begin
      p2_pick = lfsr[3:2];
    end
  end

  // State register; holds while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else if (ena) begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_round) state_nxt = S_ISSUE;
      S_ISSUE:  state_nxt = S_WAIT;
      S_WAIT:   if (cnt == 4'd0) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = (p1_score == WIN || p2_score == WIN) ? S_DONE : S_IDLE;
      S_DONE:   if (go_edge) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath: edge detect, LFSR, move latches, latency counter and scoring.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_q         <= 1'b0;
      lfsr         <= SEED;
      game_p1      <= 2'b00;
      game_p2      <= 2'b00;
      cnt          <= 4'd0;
      p1_score     <= 3'd0;
      p2_score     <= 3'd0;
      match_winner <= 2'b00;
      last_invalid <= 1'b0;
    end else if (ena) begin
      go_q <= user_go;
      lfsr <= {lfsr[6:0], lfsr_fb};
      case (state)
        S_IDLE: begin
          if (start_round) begin
            game_p1 <= user_move;
            game_p2 <= p2_pick;
          end
        end
        S_ISSUE: cnt <= CNT_LOAD;
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // This edge closes the result cycle: score it now.
            if (game_winner == 2'b01 && p1_score != WIN) p1_score <= p1_score + 3'd1;
            if (game_winner == 2'b10 && p2_score != WIN) p2_score <= p2_score + 3'd1;
            last_invalid <= (game_winner == 2'b11);
          end
        end
        S_SAMPLE: begin
          if (p1_score == WIN) begin
            match_winner <= 2'b01;
          end else if (p2_score == WIN) begin
            match_winner <= 2'b10;
          end
        end
        S_DONE: begin
          if (go_edge) begin
            p1_score     <= 3'd0;
            p2_score     <= 3'd0;
            match_winner <= 2'b00;
            last_invalid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign game_start = (state == S_ISSUE);
  assign busy       = (state == S_ISSUE) || (state == S_WAIT) || (state == S_SAMPLE);
  assign match_over = (state == S_DONE);

endmodule
